// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the byte-serial memory controller.
package mem_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DRAIN  = 2'd3
  } arb_state_e;

  // Access size codes carried in work_type[1:0]; work_type[WT_SIGNED_BIT] requests sign extension
  localparam logic [1:0]  WT_BYTE       = 2'b00;
  localparam logic [1:0]  WT_HALF       = 2'b01;
  localparam logic [1:0]  WT_WORD       = 2'b10;
  localparam int unsigned WT_SIGNED_BIT = 2;

  // Requester identities
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  // Instruction fetches are always unsigned word reads
  localparam logic [2:0] WT_IFETCH = {1'b0, WT_WORD};

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer sharing one memory controller port between ifetch and lsb.
// One transaction outstanding at a time; ifetch can be flushed without breaking the controller sequence.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [ADDR_W-1:0] if_data,
  output logic              if_ready,
  input  logic              ls_valid,
  input  logic              ls_is_write,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [ADDR_W-1:0] ls_wdata,
  input  logic [2:0]        ls_work_type,
  output logic [ADDR_W-1:0] ls_rdata,
  output logic              ls_ready,
  output logic              mc_valid,
  output logic              mc_is_write,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [ADDR_W-1:0] mc_data,
  output logic [2:0]        mc_work_type,
  input  logic [ADDR_W-1:0] mc_rdata,
  input  logic              mc_ready
);

  localparam int unsigned    CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              mc_valid_q, mc_valid_d;
  logic              mc_is_write_q, mc_is_write_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic [ADDR_W-1:0] mc_data_q, mc_data_d;
  logic [2:0]        mc_wt_q, mc_wt_d;
  logic [ADDR_W-1:0] if_data_q, if_data_d;
  logic              if_ready_q, if_ready_d;
  logic [ADDR_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              ls_ready_q, ls_ready_d;

  logic if_req_c;
  logic starved_c;
  logic gnt_v_c;
  logic gnt_id_c;

  // Grant decision: lsb has priority until ifetch has been passed over STARVE_LIMIT times
  always_comb begin
    if_req_c  = if_valid && !flush_in;
    starved_c = (starve_q == LIMIT);
    gnt_v_c   = ls_valid || if_req_c;
    gnt_id_c  = (ls_valid && !(if_req_c && starved_c)) ? REQ_LS : REQ_IF;
  end

  // Next-state and output logic; everything holds while rdy_in is low
  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    mc_valid_d    = mc_valid_q;
    mc_is_write_d = mc_is_write_q;
    mc_addr_d     = mc_addr_q;
    mc_data_d     = mc_data_q;
    mc_wt_d       = mc_wt_q;
    if_data_d     = if_data_q;
    ls_rdata_d    = ls_rdata_q;
    if_ready_d    = 1'b0;
    ls_ready_d    = 1'b0;

    if (!rdy_in) begin
      if_ready_d = if_ready_q;
      ls_ready_d = ls_ready_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!if_valid) starve_d = '0;
          if (gnt_v_c) begin
            mc_valid_d = 1'b1;
            if (gnt_id_c == REQ_LS) begin
              state_d       = ST_BUSY_D;
              mc_is_write_d = ls_is_write;
              mc_addr_d     = ls_addr;
              mc_data_d     = ls_wdata;
              mc_wt_d       = ls_work_type;
              if (if_valid && !starved_c) starve_d = starve_q + CNT_W'(1);
            end else begin
              state_d       = ST_BUSY_I;
              mc_is_write_d = 1'b0;
              mc_addr_d     = if_addr;
              mc_data_d     = '0;
              mc_wt_d       = WT_IFETCH;
              starve_d      = '0;
            end
          end
        end
        ST_BUSY_I: begin
          if (mc_ready) begin
            mc_valid_d = 1'b0;
            state_d    = ST_IDLE;
            if (!flush_in) begin
              if_data_d  = mc_rdata;
              if_ready_d = 1'b1;
            end
          end else if (flush_in) begin
            state_d = ST_DRAIN;
          end
        end
        ST_BUSY_D: begin
          if (mc_ready) begin
            mc_valid_d = 1'b0;
            state_d    = ST_IDLE;
            ls_rdata_d = mc_rdata;
            ls_ready_d = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (mc_ready) begin
            mc_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= ST_IDLE;
      starve_q      <= '0;
      mc_valid_q    <= 1'b0;
      mc_is_write_q <= 1'b0;
      mc_addr_q     <= '0;
      mc_data_q     <= '0;
      mc_wt_q       <= '0;
      if_data_q     <= '0;
      if_ready_q    <= 1'b0;
      ls_rdata_q    <= '0;
      ls_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      mc_valid_q    <= mc_valid_d;
      mc_is_write_q <= mc_is_write_d;
      mc_addr_q     <= mc_addr_d;
      mc_data_q     <= mc_data_d;
      mc_wt_q       <= mc_wt_d;
      if_data_q     <= if_data_d;
      if_ready_q    <= if_ready_d;
      ls_rdata_q    <= ls_rdata_d;
      ls_ready_q    <= ls_ready_d;
    end
  end

  assign if_data      = if_data_q;
  assign if_ready     = if_ready_q;
  assign ls_rdata     = ls_rdata_q;
  assign ls_ready     = ls_ready_q;
  assign mc_valid     = mc_valid_q;
  assign mc_is_write  = mc_is_write_q;
  assign mc_addr      = mc_addr_q;
  assign mc_data      = mc_data_q;
  assign mc_work_type = mc_wt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/responses, a monitor checks them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data;
  logic        if_ready;
  logic        ls_valid = 1'b0;
  logic        ls_is_write = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [2:0]  ls_work_type = '0;
  logic [31:0] ls_rdata;
  logic        ls_ready;
  logic        mc_valid;
  logic        mc_is_write;
  logic [31:0] mc_addr;
  logic [31:0] mc_data;
  logic [2:0]  mc_work_type;
  logic [31:0] mc_rdata = '0;
  logic        mc_ready = 1'b0;

  mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_valid(if_valid), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
    .ls_valid(ls_valid), .ls_is_write(ls_is_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_work_type(ls_work_type), .ls_rdata(ls_rdata), .ls_ready(ls_ready),
    .mc_valid(mc_valid), .mc_is_write(mc_is_write), .mc_addr(mc_addr), .mc_data(mc_data),
    .mc_work_type(mc_work_type), .mc_rdata(mc_rdata), .mc_ready(mc_ready)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        owner;
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  wt;
  } grant_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } resp_t;

  grant_t exp_grant_q[$];
  resp_t  exp_resp_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_grant(input logic owner, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] wt);
    grant_t g;
    g.owner = owner; g.is_write = wr; g.addr = a; g.data = d; g.wt = wt;
    exp_grant_q.push_back(g);
  endtask

  task automatic expect_resp(input logic owner, input logic [31:0] d);
    resp_t r;
    r.owner = owner; r.data = d;
    exp_resp_q.push_back(r);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!mc_valid && n < 50) begin
      tick();
      n++;
    end
    check("grant_wait", 32'(mc_valid), 32'd1);
  endtask

  // Pulse mc_ready for one edge and confirm the owner's ready pulse follows
  task automatic complete(input logic owner, input logic [31:0] d, input logic drop);
    mc_rdata = d;
    mc_ready = 1'b1;
    tick();
    mc_ready = 1'b0;
    if (owner == REQ_IF) begin
      check("if_ready_pulse", 32'(if_ready), 32'd1);
      check("ls_ready_quiet", 32'(ls_ready), 32'd0);
      if (drop) if_valid = 1'b0;
    end else begin
      check("ls_ready_pulse", 32'(ls_ready), 32'd1);
      check("if_ready_quiet", 32'(if_ready), 32'd0);
      if (drop) ls_valid = 1'b0;
    end
  endtask

  // Monitor: compare each new grant and each ready pulse against the scoreboard
  logic prev_v = 1'b0;
  always @(negedge clk_in) begin
    if (!rst_in) begin
      prev_v = 1'b0;
    end else begin
      if (mc_valid && !prev_v) begin
        if (exp_grant_q.size() == 0) begin
          check("grant_unexpected", 32'(mc_valid), 32'd0);
        end else begin
          grant_t g;
          g = exp_grant_q.pop_front();
          check("mc_addr", mc_addr, g.addr);
          check("mc_is_write", 32'(mc_is_write), 32'(g.is_write));
          check("mc_work_type", 32'(mc_work_type), 32'(g.wt));
          if (g.owner == REQ_LS) check("mc_data", mc_data, g.data);
        end
      end
      if (if_ready && ls_ready) check("both_ready", 32'(ls_ready), 32'd0);
      if (if_ready || ls_ready) begin
        if (exp_resp_q.size() == 0) begin
          check("ready_unexpected", {30'd0, if_ready, ls_ready}, 32'd0);
        end else begin
          resp_t r;
          r = exp_resp_q.pop_front();
          if (r.owner == REQ_IF) begin
            check("resp_owner_if", 32'(if_ready), 32'd1);
            check("if_data", if_data, r.data);
          end else begin
            check("resp_owner_ls", 32'(ls_ready), 32'd1);
            check("ls_rdata", ls_rdata, r.data);
          end
        end
      end
      prev_v = mc_valid;
    end
  end

  initial begin
    // Reset values
    #12;
    check("rst_mc_valid", 32'(mc_valid), 32'd0);
    check("rst_mc_is_write", 32'(mc_is_write), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_ls_ready", 32'(ls_ready), 32'd0);
    check("rst_mc_addr", mc_addr, 32'd0);
    check("rst_mc_data", mc_data, 32'd0);
    check("rst_mc_wt", 32'(mc_work_type), 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();

    // Single ifetch
    expect_grant(REQ_IF, 1'b0, 32'h100, 32'h0, 3'b010);
    expect_resp(REQ_IF, 32'hDEADBEEF);
    if_valid = 1'b1; if_addr = 32'h100;
    tick();
    check("grant_latency", 32'(mc_valid), 32'd1);
    tick(); tick(); tick();
    complete(REQ_IF, 32'hDEADBEEF, 1'b1);
    tick();
    check("if_ready_one_cycle", 32'(if_ready), 32'd0);

    // Contention: expect D,D,D,D,I,D
    for (int k = 0; k < 4; k++) begin
      expect_grant(REQ_LS, 1'b0, 32'h400 + 32'(k * 16), 32'hC0DE0000 + 32'(k), 3'b010);
      expect_resp(REQ_LS, 32'h1000 + 32'(k));
    end
    expect_grant(REQ_IF, 1'b0, 32'h300, 32'h0, 3'b010);
    expect_resp(REQ_IF, 32'hFEED0300);
    expect_grant(REQ_LS, 1'b0, 32'h440, 32'hC0DE0004, 3'b010);
    expect_resp(REQ_LS, 32'h1004);
    ls_valid = 1'b1; ls_is_write = 1'b0; ls_work_type = 3'b010;
    ls_addr = 32'h400; ls_wdata = 32'hC0DE0000;
    if_valid = 1'b1; if_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      wait_grant();
      tick();
      complete(REQ_LS, 32'h1000 + 32'(k), 1'b0);
      ls_addr  = 32'h400 + 32'((k + 1) * 16);
      ls_wdata = 32'hC0DE0000 + 32'(k + 1);
    end
    wait_grant();
    tick();
    complete(REQ_IF, 32'hFEED0300, 1'b1);
    wait_grant();
    tick();
    complete(REQ_LS, 32'h1004, 1'b1);
    tick();

    // Store
    expect_grant(REQ_LS, 1'b1, 32'h2004, 32'h12345678, 3'b001);
    expect_resp(REQ_LS, 32'hA5A5A5A5);
    ls_valid = 1'b1; ls_is_write = 1'b1; ls_addr = 32'h2004;
    ls_wdata = 32'h12345678; ls_work_type = 3'b001;
    wait_grant();
    tick(); tick();
    complete(REQ_LS, 32'hA5A5A5A5, 1'b1);
    ls_is_write = 1'b0;
    tick();
    check("store_ready_one_cycle", 32'(ls_ready), 32'd0);

    // Flush in IDLE blocks the grant; flush together with mc_ready drops the response
    expect_grant(REQ_IF, 1'b0, 32'h240, 32'h0, 3'b010);
    if_valid = 1'b1; if_addr = 32'h240; flush_in = 1'b1;
    tick();
    check("flush_blocks_grant", 32'(mc_valid), 32'd0);
    flush_in = 1'b0;
    tick();
    check("grant_after_flush", 32'(mc_valid), 32'd1);
    tick();
    flush_in = 1'b1; mc_ready = 1'b1; mc_rdata = 32'h0BAD0002;
    tick();
    flush_in = 1'b0; mc_ready = 1'b0; if_valid = 1'b0;
    check("flush_ready_no_pulse", 32'(if_ready), 32'd0);
    check("flush_ready_mc_valid", 32'(mc_valid), 32'd0);
    tick();

    // Flush in flight drains the controller then returns to IDLE
    expect_grant(REQ_IF, 1'b0, 32'h180, 32'h0, 3'b010);
    if_valid = 1'b1; if_addr = 32'h180;
    wait_grant();
    tick(); tick();
    flush_in = 1'b1; if_valid = 1'b0;
    tick();
    flush_in = 1'b0;
    check("drain_hold_0", 32'(mc_valid), 32'd1);
    tick(); tick();
    check("drain_hold_1", 32'(mc_valid), 32'd1);
    mc_rdata = 32'h0BAD0001; mc_ready = 1'b1;
    tick();
    mc_ready = 1'b0;
    check("drain_no_if_ready", 32'(if_ready), 32'd0);
    check("drain_mc_valid_low", 32'(mc_valid), 32'd0);
    check("drain_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    expect_grant(REQ_IF, 1'b0, 32'h200, 32'h0, 3'b010);
    expect_resp(REQ_IF, 32'h20020020);
    if_valid = 1'b1; if_addr = 32'h200;
    wait_grant();
    tick(); tick();
    complete(REQ_IF, 32'h20020020, 1'b1);
    tick();

    // rdy_in low freezes completion
    expect_grant(REQ_LS, 1'b0, 32'h3000, 32'h0, 3'b100);
    expect_resp(REQ_LS, 32'h00000077);
    ls_valid = 1'b1; ls_addr = 32'h3000; ls_wdata = 32'h0; ls_work_type = 3'b100;
    wait_grant();
    tick();
    rdy_in = 1'b0; mc_ready = 1'b1; mc_rdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frozen_no_ready", 32'(ls_ready), 32'd0);
      check("frozen_mc_valid", 32'(mc_valid), 32'd1);
    end
    rdy_in = 1'b1;
    tick();
    mc_ready = 1'b0;
    check("thaw_ready", 32'(ls_ready), 32'd1);
    ls_valid = 1'b0;
    tick();
    check("thaw_one_pulse", 32'(ls_ready), 32'd0);

    // Asynchronous reset mid BUSY_D
    expect_grant(REQ_LS, 1'b1, 32'h5000, 32'hCAFEF00D, 3'b010);
    ls_valid = 1'b1; ls_is_write = 1'b1; ls_addr = 32'h5000;
    ls_wdata = 32'hCAFEF00D; ls_work_type = 3'b010;
    wait_grant();
    tick();
    #2;
    rst_in = 1'b0;
    #1;
    check("async_rst_mc_valid", 32'(mc_valid), 32'd0);
    check("async_rst_ls_ready", 32'(ls_ready), 32'd0);
    check("async_rst_mc_addr", mc_addr, 32'd0);
    ls_valid = 1'b0; ls_is_write = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    check("post_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("post_rst_mc_valid", 32'(mc_valid), 32'd0);

    tick(); tick();
    check("grant_q_empty", 32'(exp_grant_q.size()), 32'd0);
    check("resp_q_empty", 32'(exp_resp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
